// File: rtl/board_reset_sequencer.sv
// Board reset sequencer: synchronises and debounces the reset button and PLL lock,
// then releases the SDRAM reset before the system reset. Also provides a system-only soft reset.
module board_reset_sequencer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 240000,
    parameter int unsigned SDRAM_HOLD      = 64,
    parameter int unsigned SYS_HOLD        = 64,
    parameter int unsigned CNT_WIDTH       = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    input  logic pll_locked,
    input  logic soft_req,
    output logic sdram_reset,
    output logic sys_reset,
    output logic ready
);

    typedef enum logic [2:0] {
        HOLD,
        SDRAM_WAIT,
        SYS_WAIT,
        RUN,
        SOFT
    } state_e;

    localparam logic [CNT_WIDTH-1:0] DB_TC    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SDRAM_TC = CNT_WIDTH'(SDRAM_HOLD - 1);
    localparam logic [CNT_WIDTH-1:0] SYS_TC   = CNT_WIDTH'(SYS_HOLD - 1);

    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   btn_s;
    logic                   lock_s;

    logic                   btn_db_q, btn_db_d;
    logic [CNT_WIDTH-1:0]   db_cnt_q, db_cnt_d;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CNT_WIDTH-1:0]   hold_inc;
    logic                   sdram_reset_q, sdram_reset_d;
    logic                   sys_reset_q, sys_reset_d;
    logic                   ready_q, ready_d;
    logic                   fault;

    // Button chain resets to "pressed" so the board stays in reset until a full debounce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_sync_q  <= '1;
            lock_sync_q <= '0;
        end else begin
            btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], ~btn_n};
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign btn_s  = btn_sync_q[SYNC_STAGES-1];
    assign lock_s = lock_sync_q[SYNC_STAGES-1];

    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (btn_s != btn_db_q) begin
            if (db_cnt_q == DB_TC) begin
                btn_db_d = btn_s;
            end else if (db_cnt_q != '1) begin
                db_cnt_d = db_cnt_q + 1'b1;
            end else begin
                db_cnt_d = db_cnt_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db_q <= 1'b1;
            db_cnt_q <= '0;
        end else begin
            btn_db_q <= btn_db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign fault    = btn_db_q | ~lock_s;
    assign hold_inc = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        sdram_reset_d = sdram_reset_q;
        sys_reset_d   = sys_reset_q;
        if (fault) begin
            state_d       = HOLD;
            hold_cnt_d    = '0;
            sdram_reset_d = 1'b1;
            sys_reset_d   = 1'b1;
        end else begin
            unique case (state_q)
                HOLD: begin
                    hold_cnt_d    = '0;
                    sdram_reset_d = 1'b1;
                    sys_reset_d   = 1'b1;
                    state_d       = SDRAM_WAIT;
                end
                SDRAM_WAIT: begin
                    if (hold_cnt_q == SDRAM_TC) begin
                        sdram_reset_d = 1'b0;
                        hold_cnt_d    = '0;
                        state_d       = SYS_WAIT;
                    end else begin
                        hold_cnt_d = hold_inc;
                    end
                end
                SYS_WAIT, SOFT: begin
                    if (hold_cnt_q == SYS_TC) begin
                        sys_reset_d = 1'b0;
                        hold_cnt_d  = '0;
                        state_d     = RUN;
                    end else begin
                        hold_cnt_d = hold_inc;
                    end
                end
                RUN: begin
                    if (soft_req) begin
                        sys_reset_d = 1'b1;
                        hold_cnt_d  = '0;
                        state_d     = SOFT;
                    end
                end
                default: begin
                    state_d       = HOLD;
                    hold_cnt_d    = '0;
                    sdram_reset_d = 1'b1;
                    sys_reset_d   = 1'b1;
                end
            endcase
        end
    end

    assign ready_d = ~sys_reset_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HOLD;
            hold_cnt_q    <= '0;
            sdram_reset_q <= 1'b1;
            sys_reset_q   <= 1'b1;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            sdram_reset_q <= sdram_reset_d;
            sys_reset_q   <= sys_reset_d;
            ready_q       <= ready_d;
        end
    end

    assign sdram_reset = sdram_reset_q;
    assign sys_reset   = sys_reset_q;
    assign ready       = ready_q;

endmodule
